// File: rtl/tmr_recovery_ctrl_if.sv
// Handshake bundle between the TMR recovery controller and the voter/hart side.
// slave = controller view, master = voter/hart/environment view.
interface tmr_recovery_ctrl_if #(
    parameter int NHARTS = 3
);
    logic              enable_i;
    logic              error_i;
    logic [NHARTS-1:0] error_id_i;
    logic [NHARTS-1:0] halted_i;
    logic              resync_done_i;
    logic [NHARTS-1:0] halt_req_o;
    logic              resync_start_o;
    logic [NHARTS-1:0] fault_id_o;
    logic              busy_o;
    logic              irq_o;
    logic              fatal_o;
    logic [NHARTS-1:0] perm_fault_o;

    modport slave (
        input  enable_i, error_i, error_id_i, halted_i, resync_done_i,
        output halt_req_o, resync_start_o, fault_id_o, busy_o, irq_o, fatal_o, perm_fault_o
    );

    modport master (
        output enable_i, error_i, error_id_i, halted_i, resync_done_i,
        input  halt_req_o, resync_start_o, fault_id_o, busy_o, irq_o, fatal_o, perm_fault_o
    );
endinterface

// File: rtl/tmr_recovery_ctrl.sv
// Recovery sequencer behind the TMR voter: halt -> resync -> resume on a single-hart fault,
// sticky FATAL otherwise. Optional permanent-fault tracking via TMR_RECOVERY_PERM_FAULT_EN.
module tmr_recovery_ctrl #(
    parameter int NHARTS       = 3,
    parameter int HALT_TIMEOUT = 1024,
    parameter int PERM_THRESH  = 4,
    parameter int CNT_W        = 8
) (
    input logic                clk_i,
    input logic                rst_i,
    tmr_recovery_ctrl_if.slave bus
);

    localparam int                 TIMER_W    = (HALT_TIMEOUT > 2) ? $clog2(HALT_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HALT_TIMEOUT - 1);

    if (HALT_TIMEOUT < 2 || PERM_THRESH < 1 || PERM_THRESH > (2 ** CNT_W) - 1) begin : g_bad_cfg
        $error("tmr_recovery_ctrl: invalid HALT_TIMEOUT/PERM_THRESH/CNT_W combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_RESYNC,
        S_DONE,
        S_FATAL
    } state_e;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [NHARTS-1:0]  fault_id_q, fault_id_d;
    logic               perm_hit;

    logic [NHARTS-1:0]  halt_req_q;
    logic               resync_start_q;
    logic               busy_q;
    logic               irq_q;
    logic               fatal_q;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned
        // (otherwise synthesis infers a latch).
        state_d    = state_q;
        timer_d    = timer_q;
        fault_id_d = fault_id_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.error_i && bus.enable_i) begin
                    fault_id_d = bus.error_id_i;
                    timer_d    = '0;
                    if ($countones(bus.error_id_i) == 1 && !perm_hit) state_d = S_HALT;
                    else                                              state_d = S_FATAL;
                end
            end
            S_HALT: begin
                // Halted acknowledge takes priority over a timeout in the same cycle.
                if (&bus.halted_i)              state_d = S_RESYNC;
                else if (timer_q == TIMER_LAST) state_d = S_FATAL;
                else                            timer_d = timer_q + 1'b1;
            end
            S_RESYNC: begin
                if (bus.resync_done_i) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_FATAL: state_d = S_FATAL;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            fault_id_q     <= '0;
            halt_req_q     <= '0;
            resync_start_q <= 1'b0;
            busy_q         <= 1'b0;
            irq_q          <= 1'b0;
            fatal_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            fault_id_q     <= fault_id_d;
            halt_req_q     <= (state_d inside {S_HALT, S_RESYNC, S_FATAL}) ? '1 : '0;
            resync_start_q <= (state_d == S_RESYNC) && (state_q != S_RESYNC);
            busy_q         <= (state_d != S_IDLE);
            irq_q          <= (state_d == S_DONE);
            fatal_q        <= (state_d == S_FATAL);
        end
    end

`ifdef TMR_RECOVERY_PERM_FAULT_EN
    logic [CNT_W-1:0]  charge_q [NHARTS];
    logic [NHARTS-1:0] perm_q;

    // A single-hart capture naming an already condemned hart cannot be recovered.
    assign perm_hit = |(bus.error_id_i & perm_q);

    always_ff @(posedge clk_i) begin
        // NOTE: the counter array is small and must start from zero after reset, so it is reset
        // like any other register rather than treated as uninitialised storage.
        if (rst_i) begin
            for (int i = 0; i < NHARTS; i++) charge_q[i] <= '0;
            perm_q <= '0;
        end else if (state_d == S_DONE && state_q != S_DONE) begin
            for (int i = 0; i < NHARTS; i++) begin
                if (fault_id_q[i]) begin
                    if (charge_q[i] != '1) charge_q[i] <= charge_q[i] + 1'b1;
                    if (int'(charge_q[i]) >= PERM_THRESH - 1) perm_q[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.perm_fault_o = perm_q;
`else
    assign perm_hit         = 1'b0;
    assign bus.perm_fault_o = '0;
`endif

    assign bus.halt_req_o     = halt_req_q;
    assign bus.resync_start_o = resync_start_q;
    assign bus.fault_id_o     = fault_id_q;
    assign bus.busy_o         = busy_q;
    assign bus.irq_o          = irq_q;
    assign bus.fatal_o        = fatal_q;

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Self-checking bench for tmr_recovery_ctrl: a phase-counting reference model compared every
// cycle, plus directed scenarios with literal expectations. Honours TMR_RECOVERY_PERM_FAULT_EN.
module tb_tmr_recovery_ctrl;

    localparam int HT     = 16;
    localparam int THRESH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    tmr_recovery_ctrl_if #(.NHARTS(3)) bus ();

    tmr_recovery_ctrl #(
        .NHARTS      (3),
        .HALT_TIMEOUT(HT),
        .PERM_THRESH (THRESH),
        .CNT_W       (8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: tracks where the recovery is by counting cycles in each phase.
    int         m_halt_cycles = -1;   // cycles already spent halting, -1 when not halting
    bit         m_resync = 0, m_first = 0, m_done = 0, m_fatal = 0;
    logic [2:0] m_fault = '0;
    logic [2:0] m_perm = '0;
    int         m_charges [3] = '{0, 0, 0};

    always @(posedge clk) begin
        if (rst) begin
            m_halt_cycles = -1;
            m_resync = 0; m_first = 0; m_done = 0; m_fatal = 0;
            m_fault = '0; m_perm = '0;
            m_charges = '{0, 0, 0};
        end else if (!m_fatal) begin
            m_first = 0;
            if (m_done) begin
                m_done = 0;
            end else if (m_resync) begin
                if (bus.resync_done_i) begin
                    m_resync = 0;
                    m_done = 1;
                    for (int i = 0; i < 3; i++) begin
                        if (m_fault[i]) m_charges[i]++;
`ifdef TMR_RECOVERY_PERM_FAULT_EN
                        if (m_charges[i] >= THRESH) m_perm[i] = 1'b1;
`endif
                    end
                end
            end else if (m_halt_cycles >= 0) begin
                if (bus.halted_i == 3'b111) begin
                    m_halt_cycles = -1; m_resync = 1; m_first = 1;
                end else if (m_halt_cycles + 1 == HT) begin
                    m_halt_cycles = -1; m_fatal = 1;
                end else begin
                    m_halt_cycles++;
                end
            end else if (bus.error_i && bus.enable_i) begin
                m_fault = bus.error_id_i;
                if ($countones(bus.error_id_i) == 1 && (bus.error_id_i & m_perm) == 3'b000)
                    m_halt_cycles = 0;
                else
                    m_fatal = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_halt_req", bus.halt_req_o,
                  (m_halt_cycles >= 0 || m_resync || m_fatal) ? 3'b111 : 3'b000);
            check("m_resync_start", bus.resync_start_o, m_first);
            check("m_fault_id", bus.fault_id_o, m_fault);
            check("m_busy", bus.busy_o, m_halt_cycles >= 0 || m_resync || m_done || m_fatal);
            check("m_irq", bus.irq_o, m_done);
            check("m_fatal", bus.fatal_o, m_fatal);
            check("m_perm", bus.perm_fault_o, m_perm);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.enable_i = 1'b1; bus.error_i = 1'b0; bus.error_id_i = '0;
        bus.halted_i = '0; bus.resync_done_i = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Full four-cycle recovery; ends with the controller back in IDLE.
    task automatic recover(input logic [2:0] id);
        bus.error_i = 1'b1; bus.error_id_i = id;
        step();
        bus.error_i = 1'b0; bus.halted_i = 3'b111;
        step();
        bus.halted_i = '0; bus.resync_done_i = 1'b1;
        step();
        bus.resync_done_i = 1'b0;
        step();
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_halt_req", bus.halt_req_o, 3'b000);
        check("rst_fatal", bus.fatal_o, 1'b0);

        // Single fault on hart 1.
        bus.error_i = 1'b1; bus.error_id_i = 3'b010;
        step();
        check("sf_halt_req", bus.halt_req_o, 3'b111);
        check("sf_busy", bus.busy_o, 1'b1);
        bus.error_i = 1'b0; bus.halted_i = 3'b111;
        step();
        check("sf_resync_start", bus.resync_start_o, 1'b1);
        bus.resync_done_i = 1'b1;
        step();
        check("sf_irq", bus.irq_o, 1'b1);
        check("sf_done_halt_req", bus.halt_req_o, 3'b000);
        check("sf_fault_id", bus.fault_id_o, 3'b010);
        bus.resync_done_i = 1'b0; bus.halted_i = '0;
        step();
        check("sf_idle_busy", bus.busy_o, 1'b0);
        check("sf_idle_irq", bus.irq_o, 1'b0);
        check("sf_fault_hold", bus.fault_id_o, 3'b010);

        // Multi-hart disagreement is fatal and sticky.
        bus.error_i = 1'b1; bus.error_id_i = 3'b011;
        step();
        check("mf_fatal", bus.fatal_o, 1'b1);
        bus.error_i = 1'b0;
        repeat (5) step();
        check("mf_sticky", bus.fatal_o, 1'b1);
        check("mf_halt_req", bus.halt_req_o, 3'b111);
        do_reset();
        check("mf_cleared", bus.fatal_o, 1'b0);

        // Halt timeout: fatal exactly HT cycles after entering HALT.
        bus.error_i = 1'b1; bus.error_id_i = 3'b100;
        step();
        bus.error_i = 1'b0; bus.halted_i = 3'b101;
        for (int i = 1; i < HT; i++) step();
        check("to_not_yet", bus.fatal_o, 1'b0);
        step();
        check("to_fatal", bus.fatal_o, 1'b1);
        do_reset();

        // All harts halt in the last allowed cycle: halted wins.
        bus.error_i = 1'b1; bus.error_id_i = 3'b100;
        step();
        bus.error_i = 1'b0; bus.halted_i = 3'b101;
        for (int i = 1; i < HT; i++) step();
        bus.halted_i = 3'b111;
        step();
        check("tv_resync_start", bus.resync_start_o, 1'b1);
        check("tv_no_fatal", bus.fatal_o, 1'b0);
        bus.halted_i = '0; bus.resync_done_i = 1'b1;
        step();
        check("tv_irq", bus.irq_o, 1'b1);
        bus.resync_done_i = 1'b0;
        step();
        do_reset();

        // Enable gating: errors ignored while disabled.
        bus.enable_i = 1'b0; bus.error_i = 1'b1; bus.error_id_i = 3'b010;
        repeat (3) step();
        check("gate_busy", bus.busy_o, 1'b0);
        check("gate_fault_id", bus.fault_id_o, 3'b000);
        bus.enable_i = 1'b1; bus.error_i = 1'b0;

        // Errors during RESYNC are ignored.
        bus.error_i = 1'b1; bus.error_id_i = 3'b100;
        step();
        bus.error_i = 1'b0; bus.halted_i = 3'b111;
        step();
        bus.halted_i = '0; bus.error_i = 1'b1; bus.error_id_i = 3'b001;
        repeat (3) step();
        check("mask_fault_id", bus.fault_id_o, 3'b100);
        check("mask_no_fatal", bus.fatal_o, 1'b0);
        bus.error_i = 1'b0; bus.resync_done_i = 1'b1;
        step();
        check("mask_irq", bus.irq_o, 1'b1);
        check("mask_fault_kept", bus.fault_id_o, 3'b100);
        bus.resync_done_i = 1'b0;
        step();

        // Reset in the middle of RESYNC aborts with no pulse.
        bus.error_i = 1'b1; bus.error_id_i = 3'b001;
        step();
        bus.error_i = 1'b0; bus.halted_i = 3'b111;
        step();
        bus.halted_i = '0;
        step();
        rst = 1'b1;
        step();
        check("rr_halt_req", bus.halt_req_o, 3'b000);
        check("rr_busy", bus.busy_o, 1'b0);
        check("rr_irq", bus.irq_o, 1'b0);
        check("rr_fault_id", bus.fault_id_o, 3'b000);
        rst = 1'b0;
        bus.resync_done_i = 1'b1;
        step();
        bus.resync_done_i = 1'b0;
        check("rr_after_irq", bus.irq_o, 1'b0);
        check("rr_after_busy", bus.busy_o, 1'b0);

        // Repeated faults on hart 0.
        do_reset();
        recover(3'b001);
        check("pf_first_perm", bus.perm_fault_o, 3'b000);
        recover(3'b001);
`ifdef TMR_RECOVERY_PERM_FAULT_EN
        check("pf_flagged", bus.perm_fault_o, 3'b001);
        bus.error_i = 1'b1; bus.error_id_i = 3'b001;
        step();
        bus.error_i = 1'b0;
        check("pf_fatal", bus.fatal_o, 1'b1);
`else
        check("pf_never", bus.perm_fault_o, 3'b000);
        bus.error_i = 1'b1; bus.error_id_i = 3'b001;
        step();
        bus.error_i = 1'b0;
        check("pf_recoverable", bus.halt_req_o, 3'b111);
        check("pf_no_fatal", bus.fatal_o, 1'b0);
`endif
        repeat (2) step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
